// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the two-road intersection phase scheduler:
//   - lamp colour codes RED/YEL/GRN as driven on the rA/rB signal heads
//   - tlc_phase_e : 3-bit phase/state code (also exported on the phase port)
//   - tlc_dir_e   : road identifier, A=0, B=1
// ---------------------------------------------------------------------------
package tlc_pkg;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        AR_AB = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        AR_BA = 3'd5,
        WALK  = 3'd6
    } tlc_phase_e;

    typedef enum logic {
        DIR_A = 1'b0,
        DIR_B = 1'b1
    } tlc_dir_e;

endpackage

// File: rtl/tlc_phase_timer.sv
// ---------------------------------------------------------------------------
// tlc_phase_timer
// Per-phase tick counter for the intersection scheduler.
// Ports:
//   clk      in  clock
//   rst      in  asynchronous active-high reset (count -> 0)
//   clr      in  clear the count (phase change); has priority over tick
//   tick     in  timebase strobe; the count advances only when tick=1
//   elapsed  out count+1, i.e. ticks spent in the phase including the
//                current tick; one bit wider so a saturated count cannot wrap
// The count saturates at 2^CNT_W-1.
// ---------------------------------------------------------------------------
module tlc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    output logic [CNT_W:0]   elapsed
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign elapsed = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

endmodule

// File: rtl/tlc_phase_sched.sv
// ---------------------------------------------------------------------------
// tlc_phase_sched
// Demand-driven phase scheduler for a two-road intersection (A / B):
// green -> yellow -> all-red -> opposite green, with min/max green times,
// a latched pedestrian request served by an all-red WALK phase, and all
// timing counted in ticks of an external timebase strobe.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   tick       in   1-cycle timebase strobe; transitions happen only on ticks
//   sen_a      in   vehicle present on road A (level)
//   sen_b      in   vehicle present on road B (level)
//   ped_req    in   pedestrian button (pulse or level), latched until served
//   emerg_req  in   emergency preemption request (only with EMERG_PREEMPT_EN)
//   emerg_dir  in   preempted road, 0=A 1=B (only with EMERG_PREEMPT_EN)
//   rA, rB     out  lamp codes RED=00 YEL=01 GRN=10
//   walk       out  pedestrian WALK lamp
//   phase      out  current phase code (tlc_phase_e)
// Build option: define EMERG_PREEMPT_EN to add emergency preemption.
// ---------------------------------------------------------------------------
module tlc_phase_sched
    import tlc_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int GMIN_A = 8,
    parameter int GMAX_A = 32,
    parameter int GMIN_B = 8,
    parameter int GMAX_B = 32,
    parameter int YEL_T  = 4,
    parameter int ARED_T = 2,
    parameter int PED_T  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       sen_a,
    input  logic       sen_b,
    input  logic       ped_req,
`ifdef EMERG_PREEMPT_EN
    input  logic       emerg_req,
    input  logic       emerg_dir,
`endif
    output logic [1:0] rA,
    output logic [1:0] rB,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W:0] GMIN_A_C = (CNT_W+1)'(GMIN_A);
    localparam logic [CNT_W:0] GMAX_A_C = (CNT_W+1)'(GMAX_A);
    localparam logic [CNT_W:0] GMIN_B_C = (CNT_W+1)'(GMIN_B);
    localparam logic [CNT_W:0] GMAX_B_C = (CNT_W+1)'(GMAX_B);
    localparam logic [CNT_W:0] YEL_C    = (CNT_W+1)'(YEL_T);
    localparam logic [CNT_W:0] ARED_C   = (CNT_W+1)'(ARED_T);
    localparam logic [CNT_W:0] PED_C    = (CNT_W+1)'(PED_T);

    tlc_phase_e       state_q, state_d;
    tlc_dir_e         last_dir_q, last_dir_d;
    logic             ped_pend_q, ped_pend_d;
    logic [CNT_W:0]   e;
    logic             timer_clr;
    logic             go_a;
    logic             go_b;
    logic             walk_end;
    tlc_phase_e       walk_exit;

    tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .tick    (tick),
        .elapsed (e)
    );

    // Green release conditions: min green served, opposing demand present,
    // and either no own-road demand or max green reached.
    always_comb begin
        go_a      = (e >= GMIN_A_C) && (sen_b || ped_pend_q) && (!sen_a || (e >= GMAX_A_C));
        go_b      = (e >= GMIN_B_C) && (sen_a || ped_pend_q) && (!sen_b || (e >= GMAX_B_C));
        walk_end  = (e == PED_C);
        walk_exit = (last_dir_q == DIR_A) ? B_GRN : A_GRN;
`ifdef EMERG_PREEMPT_EN
        // Preemption: hold the requested green, cut the other one and any
        // WALK short on the next tick, heading for the requested road.
        if (emerg_req) begin
            go_a      = (emerg_dir == DIR_B);
            go_b      = (emerg_dir == DIR_A);
            walk_end  = 1'b1;
            walk_exit = (emerg_dir == DIR_B) ? B_GRN : A_GRN;
        end
`else
        // No preemption: release conditions stand as computed above.
`endif
    end

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        if (tick) begin
            case (state_q)
                A_GRN: if (go_a) state_d = A_YEL;
                A_YEL: if (e == YEL_C) begin
                    state_d    = AR_AB;
                    last_dir_d = DIR_A;
                end
                AR_AB: if (e == ARED_C) state_d = ped_pend_q ? WALK : B_GRN;
                B_GRN: if (go_b) state_d = B_YEL;
                B_YEL: if (e == YEL_C) begin
                    state_d    = AR_BA;
                    last_dir_d = DIR_B;
                end
                AR_BA: if (e == ARED_C) state_d = ped_pend_q ? WALK : A_GRN;
                WALK:  if (walk_end) state_d = walk_exit;
                default: state_d = A_GRN;
            endcase
        end
    end

    assign timer_clr = (state_d != state_q);

    // A request arriving in the same cycle WALK is entered is served by
    // that WALK, so the clear dominates the set.
    always_comb begin
        ped_pend_d = ped_pend_q | ped_req;
        if ((state_d == WALK) && (state_q != WALK)) begin
            ped_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= A_GRN;
            last_dir_q <= DIR_A;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        rA   = RED;
        rB   = RED;
        walk = 1'b0;
        case (state_q)
            A_GRN:   rA   = GRN;
            A_YEL:   rA   = YEL;
            B_GRN:   rB   = GRN;
            B_YEL:   rB   = YEL;
            WALK:    walk = 1'b1;
            default: ;
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// ---------------------------------------------------------------------------
// tb_tlc_phase_sched
// Randomised bench for tlc_phase_sched. A driver issues inputs on the falling
// edge, advances an integer reference model of the phase rules and queues the
// expected lamp/phase picture; a monitor pops and compares after each rising
// edge. Stimulus runs in segments: idle rest (with timer saturation), B demand
// from rest, continuous demand (max-out), pedestrian pulses, then free random
// traffic with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_tlc_phase_sched;

    localparam int GMIN_A = 8;
    localparam int GMAX_A = 32;
    localparam int GMIN_B = 8;
    localparam int GMAX_B = 32;
    localparam int YEL_T  = 4;
    localparam int ARED_T = 2;
    localparam int PED_T  = 10;
    localparam int NCYC   = 30000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       sen_a = 1'b0;
    logic       sen_b = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] rA;
    logic [1:0] rB;
    logic       walk;
    logic [2:0] phase;
`ifdef EMERG_PREEMPT_EN
    logic       emerg_req = 1'b0;
    logic       emerg_dir = 1'b0;
`endif

    always #5 clk = ~clk;

    tlc_phase_sched #(
        .CNT_W(8), .GMIN_A(GMIN_A), .GMAX_A(GMAX_A), .GMIN_B(GMIN_B),
        .GMAX_B(GMAX_B), .YEL_T(YEL_T), .ARED_T(ARED_T), .PED_T(PED_T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .sen_a     (sen_a),
        .sen_b     (sen_b),
        .ped_req   (ped_req),
`ifdef EMERG_PREEMPT_EN
        .emerg_req (emerg_req),
        .emerg_dir (emerg_dir),
`endif
        .rA        (rA),
        .rB        (rB),
        .walk      (walk),
        .phase     (phase)
    );

    typedef struct {
        logic [2:0] ph;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       wk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: phase number, ticks spent in phase (unbounded integer),
    // pending pedestrian request, road that last went yellow (0=A, 1=B).
    int   m_phase;
    int   m_el;
    bit   m_ped;
    bit   m_last;

    function automatic exp_t picture(int ph);
        exp_t x;
        x.ph = 3'(ph);
        x.ra = (ph == 0) ? 2'b10 : (ph == 1) ? 2'b01 : 2'b00;
        x.rb = (ph == 3) ? 2'b10 : (ph == 4) ? 2'b01 : 2'b00;
        x.wk = (ph == 6);
        return x;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_el    = 0;
        m_ped   = 0;
        m_last  = 0;
    endtask

    task automatic model_step(input bit t, input bit sa, input bit sb, input bit pr,
                              input bit er, input bit ed);
        int e;
        int nxt;
        e   = m_el + 1;
        nxt = m_phase;
        if (t) begin
            case (m_phase)
                0: if (er ? ed : (e >= GMIN_A && (sb || m_ped) && (!sa || e >= GMAX_A))) nxt = 1;
                3: if (er ? !ed : (e >= GMIN_B && (sa || m_ped) && (!sb || e >= GMAX_B))) nxt = 4;
                1: if (e == YEL_T) begin nxt = 2; m_last = 0; end
                4: if (e == YEL_T) begin nxt = 5; m_last = 1; end
                2: if (e == ARED_T) nxt = m_ped ? 6 : 3;
                5: if (e == ARED_T) nxt = m_ped ? 6 : 0;
                6: if (er) nxt = ed ? 3 : 0;
                   else if (e == PED_T) nxt = m_last ? 0 : 3;
                default: nxt = 0;
            endcase
        end
        m_ped = (m_ped || pr) && !(nxt == 6 && m_phase != 6);
        if (t) m_el = (nxt != m_phase) ? 0 : e;
        m_phase = nxt;
    endtask

    // Monitor: one comparison per clock once expectations exist.
    int   cyc = 0;
    logic [2:0] prev_ph = 3'd0;
    always @(posedge clk) begin
        exp_t x;
        #1;
        cyc++;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (phase !== x.ph || rA !== x.ra || rB !== x.rb || walk !== x.wk) begin
                failures++;
                $display("FAIL lamps cyc=%0d got phase=%0d rA=%b rB=%b walk=%b expected phase=%0d rA=%b rB=%b walk=%b",
                         cyc, phase, rA, rB, walk, x.ph, x.ra, x.rb, x.wk);
            end
            if (phase !== prev_ph)
                $display("cyc=%0d phase %0d -> %0d rA=%b rB=%b walk=%b", cyc, prev_ph, phase, rA, rB, walk);
            prev_ph = phase;
        end
    end

    // Driver
    initial begin
        bit er;
        bit ed;
        er = 0;
        ed = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if (phase !== 3'd0 || rA !== 2'b10 || rB !== 2'b00 || walk !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got phase=%0d rA=%b rB=%b walk=%b expected phase=0 rA=10 rB=00 walk=0",
                     phase, rA, rB, walk);
        end
        for (int i = 0; i < NCYC; i++) begin
            if (i > 0) @(negedge clk);
            tick    = 1'($urandom_range(0, 1));
            ped_req = 1'b0;
            if (i < 600) begin
                sen_a = 0; sen_b = 0;
            end else if (i < 800) begin
                sen_a = 0; sen_b = 1;
            end else if (i < 3000) begin
                sen_a = 1; sen_b = 1;
            end else if (i < 5000) begin
                sen_a = 0; sen_b = 0;
                ped_req = ($urandom_range(0, 199) == 0);
            end else begin
                if ($urandom_range(0, 19) == 0) sen_a = ~sen_a;
                if ($urandom_range(0, 19) == 0) sen_b = ~sen_b;
                ped_req = ($urandom_range(0, 99) == 0);
`ifdef EMERG_PREEMPT_EN
                if ($urandom_range(0, 299) == 0) begin
                    er = !er;
                    ed = 1'($urandom_range(0, 1));
                end
                emerg_req = er;
                emerg_dir = ed;
`endif
            end
            if (i >= 5000 && $urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                checks++;
                if (phase !== 3'd0 || rA !== 2'b10 || rB !== 2'b00 || walk !== 1'b0) begin
                    failures++;
                    $display("FAIL async_reset got phase=%0d rA=%b rB=%b walk=%b expected phase=0 rA=10 rB=00 walk=0",
                             phase, rA, rB, walk);
                end
                q.push_back(picture(0));
            end else begin
                rst = 1'b0;
                model_step(tick, sen_a, sen_b, ped_req, er, ed);
                q.push_back(picture(m_phase));
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
